// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX pipeline segment: the decoded control word
// carried from decode into EX, its NOP value, and a small helper used by
// the load-use hazard logic.
package pipe_pkg;

   localparam int CTRL_W = 22;

   // Decoded control word, MSB first.
   typedef struct packed {
      logic [2:0] ALUOpS;
      logic [2:0] ALUOpV;
      logic       WriteVec;
      logic       Brinco;
      logic       Equal;
      logic       GEQ;
      logic       LEQ;
      logic       MemToReg;
      logic       MemRead;
      logic       MemWrite;
      logic       ALUSrc;
      logic       RegWriteS;
      logic       RegWriteV;
      logic       WriteDataSrc;
      logic       AluData;
      logic       EnableRead;
      logic       EnableWrite;
      logic       FlagRDSrc;
   } id_ctrl_t;

   // A bubble carries an all-zero control word: no writes, no memory access.
   localparam id_ctrl_t CTRL_NOP = '0;

   // True for an instruction whose result only exists after the memory
   // read, i.e. one that a dependent instruction in ID must wait for.
   function automatic logic is_load_writer(input id_ctrl_t c);
      return c.MemRead & (c.RegWriteS | c.RegWriteV);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the decode-side inputs and EX-side outputs of the ID/EX
// segment. The master drives decode fields and pipeline controls; the
// slave (the stage itself) returns the registered EX view and the stall.
interface id_ex_stage_if
   import pipe_pkg::*;
#(
   parameter int DW   = 19,
   parameter int AW   = 5,
   parameter int PCW  = 32,
   parameter int CNTW = 16
) ();

   // Decode side
   logic [PCW-1:0]  pc_id;
   logic [DW-1:0]   rd1_id;
   logic [DW-1:0]   rd2_id;
   logic [DW-1:0]   rd3_id;
   logic [DW-1:0]   imm_id;
   logic [AW-1:0]   rs1_id;
   logic [AW-1:0]   rs2_id;
   logic [AW-1:0]   rs3_id;
   logic            use_rs1_id;
   logic            use_rs2_id;
   logic            use_rs3_id;
   logic [AW-1:0]   rdst_id;
   id_ctrl_t        ctrl_id;

   // Pipeline controls
   logic            flush;
   logic            step_mode;
   logic            step_req;

   // EX side
   logic [PCW-1:0]  pc_ex;
   logic [DW-1:0]   rd1_ex;
   logic [DW-1:0]   rd2_ex;
   logic [DW-1:0]   rd3_ex;
   logic [DW-1:0]   imm_ex;
   logic [AW-1:0]   rs1_ex;
   logic [AW-1:0]   rs2_ex;
   logic [AW-1:0]   rs3_ex;
   logic [AW-1:0]   rdst_ex;
   id_ctrl_t        ctrl_ex;
   logic            valid_ex;
   logic            stall;
   logic [CNTW-1:0] bubble_cnt;

   modport master (
      output pc_id, rd1_id, rd2_id, rd3_id, imm_id,
             rs1_id, rs2_id, rs3_id, use_rs1_id, use_rs2_id, use_rs3_id,
             rdst_id, ctrl_id, flush, step_mode, step_req,
      input  pc_ex, rd1_ex, rd2_ex, rd3_ex, imm_ex,
             rs1_ex, rs2_ex, rs3_ex, rdst_ex, ctrl_ex, valid_ex,
             stall, bubble_cnt
   );

   modport slave (
      input  pc_id, rd1_id, rd2_id, rd3_id, imm_id,
             rs1_id, rs2_id, rs3_id, use_rs1_id, use_rs2_id, use_rs3_id,
             rdst_id, ctrl_id, flush, step_mode, step_req,
      output pc_ex, rd1_ex, rd2_ex, rd3_ex, imm_ex,
             rs1_ex, rs2_ex, rs3_ex, rdst_ex, ctrl_ex, valid_ex,
             stall, bubble_cnt
   );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detector. Flags the case where EX holds a valid load
// that writes a register and the instruction in ID reads that register
// through any of its source ports. Register 0 is compared like any other.
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int AW   = 5,
   parameter int NSRC = 3
) (
   input  logic                     valid_ex,
   input  id_ctrl_t                 ctrl_ex,
   input  logic [AW-1:0]            rdst_ex,
   input  logic [NSRC-1:0][AW-1:0]  rs_id,
   input  logic [NSRC-1:0]          use_rs_id,
   output logic                     haz
);

   logic [NSRC-1:0] src_match;

   // Per-source dependency check: only sources actually read count.
   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
         assign src_match[gi] = use_rs_id[gi] & (rs_id[gi] == rdst_ex);
      end
   endgenerate

   // Hazard needs a real load in EX and at least one dependent source.
   assign haz = valid_ex & is_load_writer(ctrl_ex) & (|src_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures decoded operands and control, inserts
// bubbles on branch flush or load-use hazard, holds the front-end during
// hazards and while single-step mode waits for a step request edge, and
// keeps a saturating count of the bubbles it has inserted.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DW   = 19,
   parameter int AW   = 5,
   parameter int PCW  = 32,
   parameter int CNTW = 16
) (
   input logic          clk,
   input logic          rst,
   id_ex_stage_if.slave bus
);

   logic [PCW-1:0]  pc_ex_reg;
   logic [DW-1:0]   rd1_ex_reg;
   logic [DW-1:0]   rd2_ex_reg;
   logic [DW-1:0]   rd3_ex_reg;
   logic [DW-1:0]   imm_ex_reg;
   logic [AW-1:0]   rs1_ex_reg;
   logic [AW-1:0]   rs2_ex_reg;
   logic [AW-1:0]   rs3_ex_reg;
   logic [AW-1:0]   rdst_ex_reg;
   id_ctrl_t        ctrl_ex_reg;
   logic            valid_ex_reg;
   logic [CNTW-1:0] bubble_cnt_reg;
   logic [CNTW-1:0] bubble_cnt_next;
   logic            step_q_reg;

   logic            step_edge;
   logic            adv;
   logic            haz;
   logic            do_bubble;
   logic            do_capture;

   logic [2:0][AW-1:0] rs_vec;
   logic [2:0]         use_vec;

   assign rs_vec  = {bus.rs3_id, bus.rs2_id, bus.rs1_id};
   assign use_vec = {bus.use_rs3_id, bus.use_rs2_id, bus.use_rs1_id};

   hazard_detect #(
      .AW   (AW),
      .NSRC (3)
   ) u_hazard_detect (
      .valid_ex  (valid_ex_reg),
      .ctrl_ex   (ctrl_ex_reg),
      .rdst_ex   (rdst_ex_reg),
      .rs_id     (rs_vec),
      .use_rs_id (use_vec),
      .haz       (haz)
   );

   // In step mode only a rising edge of the request lets the pipe move;
   // otherwise the pipe advances every cycle. Flush and hazard are only
   // acted on in cycles that advance.
   assign step_edge  = bus.step_req & ~step_q_reg;
   assign adv        = ~bus.step_mode | step_edge;
   assign do_bubble  = adv & (bus.flush | haz);
   assign do_capture = adv & ~bus.flush & ~haz;

   // A flush wins over a hazard so IF is free to fetch the branch target.
   assign bus.stall  = ~adv | (haz & ~bus.flush);

   // Saturating bubble counter: stop at all-ones rather than wrapping.
   always_comb begin
      bubble_cnt_next = bubble_cnt_reg;
      if (do_bubble && (bubble_cnt_reg != {CNTW{1'b1}})) begin
         bubble_cnt_next = bubble_cnt_reg + CNTW'(1);
      end
   end

   // Step request history, sampled every cycle regardless of mode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_q_reg <= 1'b0;
      end else begin
         step_q_reg <= bus.step_req;
      end
   end

   // Control/valid/counter: bubble zeroes control, capture loads it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_ex_reg    <= CTRL_NOP;
         valid_ex_reg   <= 1'b0;
         bubble_cnt_reg <= '0;
      end else begin
         bubble_cnt_reg <= bubble_cnt_next;
         if (do_bubble) begin
            ctrl_ex_reg  <= CTRL_NOP;
            valid_ex_reg <= 1'b0;
         end else if (do_capture) begin
            ctrl_ex_reg  <= bus.ctrl_id;
            valid_ex_reg <= 1'b1;
         end
      end
   end

   // Operand, index and PC registers: load on capture, otherwise hold.
   // Their contents during a bubble are meaningless to EX.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_ex_reg   <= '0;
         rd1_ex_reg  <= '0;
         rd2_ex_reg  <= '0;
         rd3_ex_reg  <= '0;
         imm_ex_reg  <= '0;
         rs1_ex_reg  <= '0;
         rs2_ex_reg  <= '0;
         rs3_ex_reg  <= '0;
         rdst_ex_reg <= '0;
      end else if (do_capture) begin
         pc_ex_reg   <= bus.pc_id;
         rd1_ex_reg  <= bus.rd1_id;
         rd2_ex_reg  <= bus.rd2_id;
         rd3_ex_reg  <= bus.rd3_id;
         imm_ex_reg  <= bus.imm_id;
         rs1_ex_reg  <= bus.rs1_id;
         rs2_ex_reg  <= bus.rs2_id;
         rs3_ex_reg  <= bus.rs3_id;
         rdst_ex_reg <= bus.rdst_id;
      end
   end

   assign bus.pc_ex      = pc_ex_reg;
   assign bus.rd1_ex     = rd1_ex_reg;
   assign bus.rd2_ex     = rd2_ex_reg;
   assign bus.rd3_ex     = rd3_ex_reg;
   assign bus.imm_ex     = imm_ex_reg;
   assign bus.rs1_ex     = rs1_ex_reg;
   assign bus.rs2_ex     = rs2_ex_reg;
   assign bus.rs3_ex     = rs3_ex_reg;
   assign bus.rdst_ex    = rdst_ex_reg;
   assign bus.ctrl_ex    = ctrl_ex_reg;
   assign bus.valid_ex   = valid_ex_reg;
   assign bus.bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for the ID/EX segment: reset, capture, load-use bubble,
// false-hazard cases, flush over hazard, single-step and counter saturation.
module tb_id_ex_stage;
   import pipe_pkg::*;

   localparam int DW   = 19;
   localparam int AW   = 5;
   localparam int PCW  = 32;
   localparam int CNTW = 16;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   id_ctrl_t c_alu;
   id_ctrl_t c_load;

   id_ex_stage_if #(.DW(DW), .AW(AW), .PCW(PCW), .CNTW(CNTW)) bus ();

   id_ex_stage #(.DW(DW), .AW(AW), .PCW(PCW), .CNTW(CNTW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [PCW-1:0] pc, input logic [DW-1:0] r1,
                        input logic [DW-1:0] r2, input logic [DW-1:0] r3,
                        input logic [DW-1:0] imm, input logic [AW-1:0] s1,
                        input logic [AW-1:0] s2, input logic [AW-1:0] s3,
                        input logic [2:0] use_bits, input logic [AW-1:0] rd,
                        input id_ctrl_t c);
      bus.pc_id      = pc;
      bus.rd1_id     = r1;
      bus.rd2_id     = r2;
      bus.rd3_id     = r3;
      bus.imm_id     = imm;
      bus.rs1_id     = s1;
      bus.rs2_id     = s2;
      bus.rs3_id     = s3;
      bus.use_rs1_id = use_bits[0];
      bus.use_rs2_id = use_bits[1];
      bus.use_rs3_id = use_bits[2];
      bus.rdst_id    = rd;
      bus.ctrl_id    = c;
      $display("txn t=%0t pc=%h rs=%0d/%0d/%0d use=%b rd=%0d ctrl=%h flush=%b step=%b/%b",
               $time, pc, s1, s2, s3, use_bits, rd, c, bus.flush, bus.step_mode, bus.step_req);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      c_alu = CTRL_NOP;
      c_alu.ALUOpS    = 3'b010;
      c_alu.RegWriteS = 1'b1;
      c_load = CTRL_NOP;
      c_load.MemRead   = 1'b1;
      c_load.MemToReg  = 1'b1;
      c_load.RegWriteS = 1'b1;
      c_load.ALUSrc    = 1'b1;

      rst = 1'b0;
      bus.flush = 1'b0;
      bus.step_mode = 1'b0;
      bus.step_req = 1'b0;
      drive(32'h0, '0, '0, '0, '0, '0, '0, '0, 3'b000, '0, CTRL_NOP);

      // Reset state before any edge
      #1;
      chk("rst_valid", bus.valid_ex, 0);
      chk("rst_ctrl", bus.ctrl_ex, 0);
      chk("rst_pc", bus.pc_ex, 0);
      chk("rst_cnt", bus.bubble_cnt, 0);
      repeat (2) tick();
      rst = 1'b1;

      // Plain capture
      drive(32'h100, 19'h1, 19'h2, 19'h3, 19'h4, 5'd1, 5'd2, 5'd3, 3'b011, 5'd7, c_alu);
      #1 chk("cap_stall", bus.stall, 0);
      tick();
      chk("cap_pc", bus.pc_ex, 32'h100);
      chk("cap_valid", bus.valid_ex, 1);
      chk("cap_ctrl", bus.ctrl_ex, c_alu);
      chk("cap_rd1", bus.rd1_ex, 19'h1);
      chk("cap_rd3", bus.rd3_ex, 19'h3);
      chk("cap_imm", bus.imm_ex, 19'h4);
      chk("cap_rs2", bus.rs2_ex, 5'd2);
      chk("cap_rdst", bus.rdst_ex, 5'd7);

      // Load-use on rs2
      drive(32'h110, 19'h10, 19'h11, 19'h12, 19'h13, 5'd1, 5'd2, 5'd3, 3'b001, 5'd5, c_load);
      #1 chk("ld_nostall", bus.stall, 0);
      tick();
      drive(32'h114, 19'h20, 19'h1234, 19'h22, 19'h23, 5'd1, 5'd5, 5'd3, 3'b011, 5'd9, c_alu);
      #1 chk("lu_stall", bus.stall, 1);
      tick();
      chk("lu_bub_valid", bus.valid_ex, 0);
      chk("lu_bub_ctrl", bus.ctrl_ex, 0);
      chk("lu_bub_cnt", bus.bubble_cnt, 1);
      chk("lu_stall_clear", bus.stall, 0);
      tick();
      chk("lu_cap_valid", bus.valid_ex, 1);
      chk("lu_cap_pc", bus.pc_ex, 32'h114);
      chk("lu_cap_rd2", bus.rd2_ex, 19'h1234);
      chk("lu_cap_ctrl", bus.ctrl_ex, c_alu);
      chk("lu_cap_cnt", bus.bubble_cnt, 1);

      // No hazard: matching index but not read
      drive(32'h118, 19'h30, 19'h31, 19'h32, 19'h33, 5'd1, 5'd2, 5'd3, 3'b001, 5'd5, c_load);
      tick();
      drive(32'h11c, 19'h40, 19'h41, 19'h42, 19'h43, 5'd1, 5'd5, 5'd5, 3'b001, 5'd5, c_alu);
      #1 chk("nouse_stall", bus.stall, 0);
      tick();
      chk("nouse_pc", bus.pc_ex, 32'h11c);
      chk("nouse_valid", bus.valid_ex, 1);
      chk("nouse_cnt", bus.bubble_cnt, 1);

      // No hazard: EX is not a load
      drive(32'h120, 19'h50, 19'h51, 19'h52, 19'h53, 5'd5, 5'd5, 5'd5, 3'b111, 5'd6, c_alu);
      #1 chk("noload_stall", bus.stall, 0);
      tick();
      chk("noload_pc", bus.pc_ex, 32'h120);
      chk("noload_cnt", bus.bubble_cnt, 1);

      // Flush together with an rs3 hazard: one bubble, no stall
      drive(32'h124, 19'h60, 19'h61, 19'h62, 19'h63, 5'd1, 5'd2, 5'd3, 3'b000, 5'd6, c_load);
      tick();
      drive(32'h128, 19'h70, 19'h71, 19'h72, 19'h73, 5'd1, 5'd2, 5'd6, 3'b100, 5'd8, c_alu);
      bus.flush = 1'b1;
      #1 chk("fl_stall", bus.stall, 0);
      tick();
      bus.flush = 1'b0;
      chk("fl_valid", bus.valid_ex, 0);
      chk("fl_ctrl", bus.ctrl_ex, 0);
      chk("fl_cnt", bus.bubble_cnt, 2);
      tick();
      chk("fl_after_pc", bus.pc_ex, 32'h128);
      chk("fl_after_valid", bus.valid_ex, 1);
      chk("fl_after_cnt", bus.bubble_cnt, 2);

      // Load-use through register 0 on rs3
      drive(32'h12c, 19'h80, 19'h81, 19'h82, 19'h83, 5'd1, 5'd2, 5'd3, 3'b000, 5'd0, c_load);
      tick();
      drive(32'h130, 19'h90, 19'h91, 19'h92, 19'h93, 5'd1, 5'd2, 5'd0, 3'b100, 5'd4, c_alu);
      #1 chk("r0_stall", bus.stall, 1);
      tick();
      chk("r0_valid", bus.valid_ex, 0);
      chk("r0_cnt", bus.bubble_cnt, 3);
      tick();
      chk("r0_cap_pc", bus.pc_ex, 32'h130);

      // Reset mid-stream after five instructions
      for (int i = 0; i < 5; i++) begin
         drive(32'h140 + 32'(4 * i), 19'(i + 1), 19'h0, 19'h0, 19'h0, 5'd1, 5'd2, 5'd3,
               3'b000, 5'(10 + i), c_alu);
         tick();
      end
      chk("ms_pc", bus.pc_ex, 32'h150);
      chk("ms_rd1", bus.rd1_ex, 19'h5);
      #2 rst = 1'b0;
      #1;
      chk("ms_rst_pc", bus.pc_ex, 0);
      chk("ms_rst_valid", bus.valid_ex, 0);
      chk("ms_rst_ctrl", bus.ctrl_ex, 0);
      chk("ms_rst_cnt", bus.bubble_cnt, 0);
      chk("ms_rst_rd1", bus.rd1_ex, 0);
      chk("ms_rst_rdst", bus.rdst_ex, 0);
      drive(32'h200, 19'h7, 19'h8, 19'h9, 19'ha, 5'd1, 5'd2, 5'd3, 3'b000, 5'd11, c_alu);
      tick();
      chk("ms_held_pc", bus.pc_ex, 0);
      rst = 1'b1;
      tick();
      chk("ms_rel_pc", bus.pc_ex, 32'h200);
      chk("ms_rel_valid", bus.valid_ex, 1);

      // Single step: one advance per request edge
      bus.step_mode = 1'b1;
      drive(32'h2f0, 19'h0, 19'h0, 19'h0, 19'h0, 5'd1, 5'd2, 5'd3, 3'b000, 5'd12, c_alu);
      #1 chk("st_idle_stall", bus.stall, 1);
      tick();
      chk("st_idle_pc", bus.pc_ex, 32'h200);
      bus.step_req = 1'b1;
      drive(32'h300, 19'h0, 19'h0, 19'h0, 19'h0, 5'd1, 5'd2, 5'd3, 3'b000, 5'd12, c_alu);
      #1 chk("st1_stall", bus.stall, 0);
      tick();
      chk("st1_pc", bus.pc_ex, 32'h300);
      bus.flush = 1'b1;
      for (int k = 1; k < 10; k++) begin
         drive(32'h300 + 32'(4 * k), 19'h0, 19'h0, 19'h0, 19'h0, 5'd1, 5'd2, 5'd3,
               3'b000, 5'd12, c_alu);
         #1 chk("st_hold_stall", bus.stall, 1);
         tick();
         chk("st_hold_pc", bus.pc_ex, 32'h300);
         chk("st_hold_cnt", bus.bubble_cnt, 0);
      end
      bus.flush = 1'b0;
      chk("st_hold_valid", bus.valid_ex, 1);
      bus.step_req = 1'b0;
      drive(32'h400, 19'h0, 19'h0, 19'h0, 19'h0, 5'd1, 5'd2, 5'd3, 3'b000, 5'd12, c_alu);
      #1 chk("st_low_stall", bus.stall, 1);
      tick();
      chk("st_low_pc", bus.pc_ex, 32'h300);
      bus.step_req = 1'b1;
      drive(32'h404, 19'h0, 19'h0, 19'h0, 19'h0, 5'd1, 5'd2, 5'd3, 3'b000, 5'd12, c_alu);
      #1 chk("st2_stall", bus.stall, 0);
      tick();
      chk("st2_pc", bus.pc_ex, 32'h404);
      #1 chk("st2_hold_stall", bus.stall, 1);
      tick();
      chk("st2_hold_pc", bus.pc_ex, 32'h404);

      // Step mode entered with request already high: no advance
      bus.step_mode = 1'b0;
      drive(32'h500, 19'h0, 19'h0, 19'h0, 19'h0, 5'd1, 5'd2, 5'd3, 3'b000, 5'd12, c_alu);
      tick();
      chk("free_pc", bus.pc_ex, 32'h500);
      bus.step_mode = 1'b1;
      drive(32'h504, 19'h0, 19'h0, 19'h0, 19'h0, 5'd1, 5'd2, 5'd3, 3'b000, 5'd12, c_alu);
      #1 chk("pre_high_stall", bus.stall, 1);
      tick();
      chk("pre_high_pc", bus.pc_ex, 32'h500);
      bus.step_req = 1'b0;
      tick();
      bus.step_req = 1'b1;
      tick();
      chk("re_edge_pc", bus.pc_ex, 32'h504);

      // Bubble counter saturation under continuous flush
      bus.step_mode = 1'b0;
      bus.step_req = 1'b0;
      bus.flush = 1'b1;
      $display("txn t=%0t continuous flush for 65537 cycles", $time);
      repeat (65534) tick();
      chk("sat_fffe", bus.bubble_cnt, 16'hfffe);
      repeat (3) tick();
      chk("sat_ffff", bus.bubble_cnt, 16'hffff);
      chk("sat_valid", bus.valid_ex, 0);
      bus.flush = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline segment of the scalar/vector pipeline, between decode (register-file reads, immediate extend, control decode) and the EX-stage ALU/branch logic.
- Registers the decoded operands and control word.
- Detects load-use hazards and freezes PC and IF/ID on them.
- Inserts bubbles on hazard or branch flush.
- Supports single-step mode: the whole front-end advances one instruction per step request.

Parameters:
- DW, 19: operand/immediate data width.
- AW, 5: register index width.
- PCW, 32: program counter width.
- CNTW, 16: bubble counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-low.
- pc_id  in  PCW  PC of the instruction in ID.
- rd1_id, rd2_id, rd3_id  in  DW each  register-file read data.
- imm_id  in  DW  extended immediate.
- rs1_id, rs2_id, rs3_id  in  AW each  source indices.
- use_rs1_id, use_rs2_id, use_rs3_id  in  1 each  source actually read.
- rdst_id  in  AW  destination index.
- ctrl_id  in  22  decoded control word (id_ctrl_t).
- flush  in  1  branch taken in EX (PCSource).
- step_mode  in  1  single-step enable.
- step_req  in  1  step request level (synchronous to clk).
- pc_ex  out  PCW  registered PC.
- rd1_ex, rd2_ex, rd3_ex, imm_ex  out  DW each  registered operands.
- rs1_ex, rs2_ex, rs3_ex, rdst_ex  out  AW each  registered indices.
- ctrl_ex  out  22  registered control word.
- valid_ex  out  1  EX holds a real instruction.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- bubble_cnt  out  CNTW  saturating count of inserted bubbles.

Behaviour:
- Reset (rst=0, any time, asynchronous): every registered output is 0, valid_ex=0, bubble_cnt=0, step edge register=0. Effect is immediate, with no clock edge required.
- Step edge detect:
  - step_q <= step_req every cycle.
  - step_edge = step_req & ~step_q.
  - adv = ~step_mode | step_edge.
- Load-use hazard: haz = valid_ex & ctrl_ex.MemRead & (ctrl_ex.RegWriteS | ctrl_ex.RegWriteV) & ((use_rs1_id & rs1_id==rdst_ex) | (use_rs2_id & rs2_id==rdst_ex) | (use_rs3_id & rs3_id==rdst_ex)).
  - Index 0 gets no special treatment.
- stall = ~adv | (haz & ~flush). A flush overrides a hazard so IF can load the branch target.
- Register update on each rising clk edge, evaluated in priority order:
  1. ~adv: hold all registers. No bubble, no count.
  2. flush: bubble.
  3. haz: bubble.
  4. Otherwise: capture all *_id inputs and set valid_ex=1.
- Bubble: valid_ex=0, ctrl_ex=0. The data/index/PC registers may hold or capture; they are don't-care, but the bench checks ctrl_ex=0.
- Hazard latency: exactly one bubble per load-use. The bubble clears haz on the next cycle, and the ID instruction then captures.
- bubble_cnt:
  - Increments by 1 on every bubble cycle.
  - Saturates at 2^CNTW-1; never wraps.
- In step mode: flush and haz are sampled only on the adv cycle. A step_req held high produces exactly one advance. step_req already high when step_mode rises produces no advance until it falls and rises again.

Decomposition:
- Package pipe_pkg holds:
  - Typedef id_ctrl_t, packed 22 bits, MSB first: ALUOpS[2:0], ALUOpV[2:0], WriteVec, Brinco, Equal, GEQ, LEQ, MemToReg, MemRead, MemWrite, ALUSrc, RegWriteS, RegWriteV, WriteDataSrc, AluData, EnableRead, EnableWrite, FlagRDSrc.
  - Constant CTRL_NOP = '0.
- One sub-module, hazard_detect: purely combinational, computes haz from the EX and ID fields.

Test Plan:
- Reset mid-stream: run 5 valid instructions, pull rst=0 between edges → all outputs 0 immediately, including valid_ex=0 and bubble_cnt=0. Release → first instruction captures on the next edge.
- Load-use: EX holds MemRead=1, RegWriteS=1, rdst=5; ID has rs2=5, use_rs2=1 → stall=1 that cycle. Next edge: valid_ex=0, ctrl_ex=0, bubble_cnt=1. Next edge: stall=0 and the ID instruction appears with valid_ex=1.
- No false hazard: same case but use_rs2=0, or EX MemRead=0 → stall=0, capture normally, bubble_cnt unchanged.
- Flush with simultaneous hazard: flush=1 and haz true → stall=0. Next edge: valid_ex=0, bubble_cnt+1 (one count only).
- Step mode: step_mode=1, step_req high for 10 cycles then low, then high again → exactly two captures total. stall=1 on all other cycles. Registers are unchanged while holding.
- Saturation: force 65537 consecutive flush cycles → bubble_cnt stops at 0xFFFF and does not return to 0.
